// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryptor: one round per clock and a fixed key schedule, with valid/ready on both sides.
// Define AES_ENC_FULL_WIDTH_EN to take a full 128-bit plaintext block instead of a zero-extended 32-bit word.

module aes_enc_mixcol (
    input  logic [31:0] col,
    output logic [31:0] mixed
);
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] a0, a1, a2, a3;
    assign {a0, a1, a2, a3} = col;

    assign mixed = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                    a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                    a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                    xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
endmodule

module aes_encrypt_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
`ifdef AES_ENC_FULL_WIDTH_EN
    input  logic [127:0] plaintext,
`else
    input  logic [31:0]  plaintext,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext
);
    localparam int NCOL = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Expanded schedule of the fixed link key 2b7e1516_28aed2a6_abf71588_09cf4f3c.
    function automatic logic [127:0] round_key(input logic [3:0] r);
        logic [127:0] k;
        case (r)
            4'd0:    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
            4'd1:    k = 128'ha0fafe1788542cb123a339392a6c7605;
            4'd2:    k = 128'hf2c295f27a96b9435935807a7359f67f;
            4'd3:    k = 128'h3d80477d4716fe3e1e237e446d7a883b;
            4'd4:    k = 128'hef44a541a8525b7fb671253bdb0bad00;
            4'd5:    k = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
            4'd6:    k = 128'h6d88a37a110b3efddbf98641ca0093fd;
            4'd7:    k = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
            4'd8:    k = 128'head27321b58dbad2312bf5607f8d292f;
            4'd9:    k = 128'hac7766f319fadc2128d12941575c006e;
            4'd10:   k = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
            default: k = 128'h0;
        endcase
        return k;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = SBOX[s[127-8*i -: 8]];
        return o;
    endfunction

    // Byte i is row i%4, column i/4; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    logic [1:0]   fsm;
    logic [3:0]   rnd;
    logic [127:0] st;
    logic [127:0] ct;
    logic [127:0] blk_in;
    logic [127:0] sr_st;
    logic [127:0] mc_st;
    logic [127:0] nxt;

`ifdef AES_ENC_FULL_WIDTH_EN
    assign blk_in = plaintext;
`else
    assign blk_in = {96'h0, plaintext};
`endif

    assign sr_st = shift_rows(sub_bytes(st));

    for (genvar c = 0; c < NCOL; c++) begin : g_col
        aes_enc_mixcol u_mix (
            .col   (sr_st[127-32*c -: 32]),
            .mixed (mc_st[127-32*c -: 32])
        );
    end

    // Final round drops MixColumns.
    assign nxt = ((rnd == 4'd10) ? sr_st : mc_st) ^ round_key(rnd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm <= IDLE;
            rnd <= 4'd0;
            st  <= '0;
            ct  <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        st  <= blk_in ^ round_key(4'd0);
                        rnd <= 4'd1;
                        fsm <= RUN;
                    end
                end
                RUN: begin
                    st  <= nxt;
                    rnd <= rnd + 4'd1;
                    if (rnd == 4'd10) begin
                        ct  <= nxt;
                        fsm <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        fsm <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign in_ready   = (fsm == IDLE);
    assign out_valid  = (fsm == DONE);
    assign ciphertext = ct;
endmodule
